lcd1602_ctrl: RTL and testbench
===============================

Name: lcd1602_ctrl

Overview:
- Sequencer for an HD44780-compatible 1602 character LCD in 8-bit, write-only mode.
- Runs the power-on init sequence itself, then serialises command and character writes from one upstream requester through a valid/ready handshake.
- Generates every pin waveform (rs, rw, en, dat) with parameterised setup, enable-pulse and execution-wait timing, so text and menu logic never handle LCD timing.
- Sits between a 50 MHz system clock domain and the LCD pins.

Parameters:
- SETUP_CYC, 4: cycles rs/dat are stable before en rises (at least 40 ns).
- EN_HI_CYC, 25: en high width in cycles (at least 450 ns).
- HOLD_CYC, 4: cycles rs/dat are held after en falls.
- CMD_WAIT_CYC, 2500: execution wait after a normal command or data write (50 us).
- CLR_WAIT_CYC, 100000: execution wait after clear (0x01) or home (0x02/0x03) with rs=0 (2 ms).
- PWR_WAIT_CYC, 1000000: wait after reset before the first init command (20 ms).

Ports:
- clk, in, 1: system clock, 50 MHz.
- rst, in, 1: synchronous reset, active-high.
- req_valid, in, 1: request present.
- req_ready, out, 1: controller can accept a request.
- req_rs, in, 1: 0 = command, 1 = character data.
- req_data, in, 8: command byte or character code.
- init_done, out, 1: high once the init sequence has completed; stays high until rst.
- lcd_dat, out, 8: LCD data bus.
- lcd_rs, out, 1: LCD register select.
- lcd_rw, out, 1: LCD read/write; tied 0 (write only).
- lcd_en, out, 1: LCD enable strobe.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst).
- Reset values: lcd_dat=0x00, lcd_rs=0, lcd_rw=0, lcd_en=0, req_ready=0, init_done=0. All counters clear to 0. A rst during any state aborts at once: en drops the same cycle, and the controller restarts from PWR_WAIT.
- Top FSM: PWR_WAIT -> INIT -> IDLE -> XFER -> IDLE.
  - PWR_WAIT lasts exactly PWR_WAIT_CYC cycles.
  - INIT issues, through XFER, commands 0x38, 0x0C, 0x06, 0x01 in that order, all with rs=0.
  - init_done rises on the first IDLE cycle after the 0x01 wait completes.
- Transfer sub-FSM (XFER): SETUP (SETUP_CYC) -> EN_HI (EN_HI_CYC) -> HOLD (HOLD_CYC) -> WAIT (CMD_WAIT_CYC or CLR_WAIT_CYC).
  - lcd_dat and lcd_rs are registered at SETUP entry and are constant until WAIT ends.
  - lcd_en is high only during EN_HI.
  - The long wait applies when rs=0 and data is 0x01, 0x02 or 0x03.
- Handshake:
  - req_ready=1 only in IDLE with init_done=1. Requests arriving during init are not accepted; req_valid may stay high and is accepted after init.
  - Accept on the cycle where req_valid & req_ready. req_ready goes 0 on the next cycle, the same cycle SETUP starts.
  - req_rs and req_data are captured at accept; upstream may change them afterwards.
  - Back-to-back: req_ready returns to 1 on the cycle after WAIT ends. A request held valid is accepted that cycle, giving no idle bubble beyond that one cycle.
  - Minimum accept-to-accept spacing for a normal write: 1+SETUP_CYC+EN_HI_CYC+HOLD_CYC+CMD_WAIT_CYC cycles.
- Counter: a single down-counter, wide enough for PWR_WAIT_CYC (20 bits at defaults), reloaded on each phase entry; a phase ends when it reaches 0.
- lcd_rw is constant 0.

Optional Feature:
- Macro: LCD1602_LINE_WRAP_EN.
- Defined:
  - The controller tracks the cursor as a line bit plus a 4-bit column.
  - A data write (rs=1) increments the column. On column wrap 15->0 it toggles the line, and before returning to IDLE it auto-issues a set-DDRAM command: 0xC0 for line 1, 0x80 for line 0. That command goes through a full XFER, and req_ready stays 0 throughout.
  - Accepted commands with rs=0 and data[7]=1 load the tracker from data: line = data[6], column = data[3:0].
  - 0x01, 0x02 and 0x03 zero the tracker.
  - Init leaves the tracker at line 0, column 0.
- Undefined: no tracking and no inserted commands; the LCD's native DDRAM addressing applies, so character 17 lands off-screen.

Decomposition:
- Package lcd1602_pkg holds:
  - the init command constants (0x38, 0x0C, 0x06, 0x01);
  - LINE0_ADDR = 0x80 and LINE1_ADDR = 0xC0;
  - the top and XFER state enums.
- Sub-module lcd1602_xfer contains the SETUP/EN_HI/HOLD/WAIT timing engine, with a start/byte/rs/long-wait input and a done pulse. The top FSM, init ROM, handshake and wrap tracker live in lcd1602_ctrl.

Test Plan:
- Bench uses overrides PWR_WAIT_CYC=50, CMD_WAIT_CYC=20, CLR_WAIT_CYC=60, SETUP/EN_HI/HOLD=2/3/2 throughout.
- Reset release -> exactly 4 en pulses carrying 0x38, 0x0C, 0x06, 0x01 with rs=0. init_done rises 60 wait cycles after the last pulse; req_ready=0 before that.
- Write req_rs=1, req_data=0x48 ('H') -> one en pulse 3 cycles wide, rs=1, dat=0x48 stable from SETUP through HOLD. req_ready returns after 1+2+3+2+20 cycles.
- req_valid held high with 3 queued bytes -> accepts exactly one per 28 cycles. No byte is dropped or duplicated, and en pulse count = 3.
- Command 0x01 after init -> WAIT lasts 60 cycles, not 20.
- Assert rst during EN_HI -> lcd_en=0 on the next edge, then a full re-init; a pending request is not issued before init_done.
- LCD1602_LINE_WRAP_EN defined, 17 data writes -> en pulse 17 carries 0xC0 with rs=0, pulse 18 carries the 17th character. With the macro undefined -> 17 data pulses and no 0xC0.

Source files
------------

// File: rtl/lcd1602_pkg.sv
// Shared constants and state encodings for the 1602 LCD controller.
// Contents: init command bytes, DDRAM line addresses, top/XFER state
// enums and the init ROM lookup used by lcd1602_ctrl.
package lcd1602_pkg;

   localparam logic [7:0] CMD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
   localparam logic [7:0] CMD_DISP_ON  = 8'h0C;  // display on, cursor off
   localparam logic [7:0] CMD_ENTRY    = 8'h06;  // increment, no shift
   localparam logic [7:0] CMD_CLEAR    = 8'h01;

   localparam logic [7:0] LINE0_ADDR   = 8'h80;
   localparam logic [7:0] LINE1_ADDR   = 8'hC0;

   localparam int unsigned INIT_LEN    = 4;

   typedef enum logic [2:0] {
      T_PWR_WAIT,
      T_INIT,
      T_IDLE,
      T_XFER,
      T_WRAP
   } top_state_t;

   typedef enum logic [2:0] {
      X_PWR,
      X_IDLE,
      X_SETUP,
      X_EN_HI,
      X_HOLD,
      X_WAIT
   } xfer_state_t;

   // Init sequence ROM.
   function automatic logic [7:0] init_cmd(input logic [1:0] idx);
      logic [7:0] cmd;
      case (idx)
         2'd0:    cmd = CMD_FUNC_SET;
         2'd1:    cmd = CMD_DISP_ON;
         2'd2:    cmd = CMD_ENTRY;
         default: cmd = CMD_CLEAR;
      endcase
      return cmd;
   endfunction

endpackage

// File: rtl/lcd1602_xfer.sv
// Pin timing engine for one LCD write: SETUP -> EN_HI -> HOLD -> WAIT.
// Also owns the power-on wait, so a single down-counter times every phase.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start           : begin a write (only honoured while idle)
//   data, rs        : byte and register select, captured on start
//   long_wait       : use CLR_WAIT_CYC instead of CMD_WAIT_CYC
//   lcd_dat/rs/en   : registered LCD pins
//   done_c          : high on the last cycle of the power wait or of WAIT
module lcd1602_xfer
   import lcd1602_pkg::*;
#(
   parameter int unsigned SETUP_CYC    = 4,
   parameter int unsigned EN_HI_CYC    = 25,
   parameter int unsigned HOLD_CYC     = 4,
   parameter int unsigned CMD_WAIT_CYC = 2500,
   parameter int unsigned CLR_WAIT_CYC = 100000,
   parameter int unsigned PWR_WAIT_CYC = 1000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] data,
   input  logic       rs,
   input  logic       long_wait,
   output logic [7:0] lcd_dat,
   output logic       lcd_rs,
   output logic       lcd_en,
   output logic       done_c
);

   localparam int unsigned MAX_A   = (SETUP_CYC > EN_HI_CYC) ? SETUP_CYC : EN_HI_CYC;
   localparam int unsigned MAX_B   = (HOLD_CYC > CMD_WAIT_CYC) ? HOLD_CYC : CMD_WAIT_CYC;
   localparam int unsigned MAX_C   = (CLR_WAIT_CYC > PWR_WAIT_CYC) ? CLR_WAIT_CYC : PWR_WAIT_CYC;
   localparam int unsigned MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int unsigned MAX_CYC = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
   localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

   xfer_state_t      state;
   logic [CNT_W-1:0] cnt;
   logic             pwr_load;
   logic             long_q;

   // Counter clears to 0 in reset, so the power wait spends its first
   // cycle loading and then counts PWR_WAIT_CYC-2 down to 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= X_PWR;
         cnt      <= '0;
         pwr_load <= 1'b1;
         long_q   <= 1'b0;
         lcd_dat  <= 8'h00;
         lcd_rs   <= 1'b0;
         lcd_en   <= 1'b0;
      end else begin
         case (state)
            X_PWR: begin
               if (pwr_load) begin
                  pwr_load <= 1'b0;
                  cnt      <= CNT_W'(PWR_WAIT_CYC - 2);
               end else if (cnt == '0) begin
                  state <= X_IDLE;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            X_IDLE: begin
               if (start) begin
                  state   <= X_SETUP;
                  cnt     <= CNT_W'(SETUP_CYC - 1);
                  lcd_dat <= data;
                  lcd_rs  <= rs;
                  long_q  <= long_wait;
               end
            end
            X_SETUP: begin
               if (cnt == '0) begin
                  state  <= X_EN_HI;
                  cnt    <= CNT_W'(EN_HI_CYC - 1);
                  lcd_en <= 1'b1;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            X_EN_HI: begin
               if (cnt == '0) begin
                  state  <= X_HOLD;
                  cnt    <= CNT_W'(HOLD_CYC - 1);
                  lcd_en <= 1'b0;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            X_HOLD: begin
               if (cnt == '0) begin
                  state <= X_WAIT;
                  cnt   <= long_q ? CNT_W'(CLR_WAIT_CYC - 1) : CNT_W'(CMD_WAIT_CYC - 1);
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            X_WAIT: begin
               if (cnt == '0) begin
                  state <= X_IDLE;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: begin
               state  <= X_IDLE;
               lcd_en <= 1'b0;
            end
         endcase
      end
   end

   assign done_c = (cnt == '0) && !pwr_load && ((state == X_WAIT) || (state == X_PWR));

endmodule

// File: rtl/lcd1602_ctrl.sv
// HD44780 1602 LCD controller, 8-bit write-only.
// Runs the power-on init sequence, then serialises upstream command and
// character writes via a valid/ready handshake.
// Ports:
//   clk, rst                    : 50 MHz clock, synchronous active-high reset
//   req_valid/req_ready         : request handshake
//   req_rs, req_data            : 0 = command, 1 = character; payload byte
//   init_done                   : init sequence complete (sticky until rst)
//   lcd_dat, lcd_rs, lcd_rw, lcd_en : LCD pins (lcd_rw tied 0)
// Optional: define LCD1602_LINE_WRAP_EN to track the cursor and insert a
// set-DDRAM command whenever a character write wraps column 15 -> 0.
module lcd1602_ctrl
   import lcd1602_pkg::*;
#(
   parameter int unsigned SETUP_CYC    = 4,
   parameter int unsigned EN_HI_CYC    = 25,
   parameter int unsigned HOLD_CYC     = 4,
   parameter int unsigned CMD_WAIT_CYC = 2500,
   parameter int unsigned CLR_WAIT_CYC = 100000,
   parameter int unsigned PWR_WAIT_CYC = 1000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_rs,
   input  logic [7:0] req_data,
   output logic       init_done,
   output logic [7:0] lcd_dat,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic       lcd_en
);

   top_state_t state;
   logic [1:0] init_idx;
   logic       start_c;
   logic [7:0] cmd_byte_c;
   logic       cmd_rs_c;
   logic       long_c;
   logic       xfer_done_c;

`ifdef LCD1602_LINE_WRAP_EN
   logic       cur_line;
   logic [3:0] cur_col;
   logic       wrap_pend;
`endif

   assign lcd_rw = 1'b0;

   // Select what to hand to the timing engine this cycle.
   always_comb begin
      start_c    = 1'b0;
      cmd_byte_c = req_data;
      cmd_rs_c   = req_rs;
      case (state)
         T_INIT: begin
            start_c    = 1'b1;
            cmd_byte_c = init_cmd(init_idx);
            cmd_rs_c   = 1'b0;
         end
         T_IDLE: begin
            start_c = req_valid & req_ready;
         end
`ifdef LCD1602_LINE_WRAP_EN
         T_WRAP: begin
            start_c    = 1'b1;
            cmd_byte_c = cur_line ? LINE1_ADDR : LINE0_ADDR;
            cmd_rs_c   = 1'b0;
         end
`endif
         default: ;
      endcase
   end

   // Clear (0x01) and home (0x02/0x03) need the long execution wait.
   assign long_c = !cmd_rs_c && (cmd_byte_c[7:2] == 6'd0) && (cmd_byte_c[1:0] != 2'd0);

   // Top sequencer: power wait, init ROM, handshake, optional wrap insert.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= T_PWR_WAIT;
         init_idx  <= 2'd0;
         init_done <= 1'b0;
         req_ready <= 1'b0;
`ifdef LCD1602_LINE_WRAP_EN
         cur_line  <= 1'b0;
         cur_col   <= 4'd0;
         wrap_pend <= 1'b0;
`endif
      end else begin
         case (state)
            T_PWR_WAIT: begin
               if (xfer_done_c) state <= T_INIT;
            end
            T_INIT: begin
               state <= T_XFER;
            end
            T_IDLE: begin
               if (start_c) begin
                  state     <= T_XFER;
                  req_ready <= 1'b0;
`ifdef LCD1602_LINE_WRAP_EN
                  if (req_rs) begin
                     cur_col <= cur_col + 4'd1;
                     if (cur_col == 4'hF) begin
                        cur_line  <= ~cur_line;
                        wrap_pend <= 1'b1;
                     end
                  end else if (req_data[7]) begin
                     cur_line <= req_data[6];
                     cur_col  <= req_data[3:0];
                  end else if (long_c) begin
                     cur_line <= 1'b0;
                     cur_col  <= 4'd0;
                  end
`endif
               end
            end
            T_XFER: begin
               if (xfer_done_c) begin
                  if (!init_done) begin
                     if (init_idx == 2'(INIT_LEN - 1)) begin
                        state     <= T_IDLE;
                        init_done <= 1'b1;
                        req_ready <= 1'b1;
                     end else begin
                        init_idx <= init_idx + 2'd1;
                        state    <= T_INIT;
                     end
                  end
`ifdef LCD1602_LINE_WRAP_EN
                  else if (wrap_pend) begin
                     state <= T_WRAP;
                  end
`endif
                  else begin
                     state     <= T_IDLE;
                     req_ready <= 1'b1;
                  end
               end
            end
`ifdef LCD1602_LINE_WRAP_EN
            T_WRAP: begin
               state     <= T_XFER;
               wrap_pend <= 1'b0;
            end
`endif
            default: begin
               state     <= T_PWR_WAIT;
               req_ready <= 1'b0;
            end
         endcase
      end
   end

   lcd1602_xfer #(
      .SETUP_CYC    (SETUP_CYC),
      .EN_HI_CYC    (EN_HI_CYC),
      .HOLD_CYC     (HOLD_CYC),
      .CMD_WAIT_CYC (CMD_WAIT_CYC),
      .CLR_WAIT_CYC (CLR_WAIT_CYC),
      .PWR_WAIT_CYC (PWR_WAIT_CYC)
   ) u_xfer (
      .clk       (clk),
      .rst       (rst),
      .start     (start_c),
      .data      (cmd_byte_c),
      .rs        (cmd_rs_c),
      .long_wait (long_c),
      .lcd_dat   (lcd_dat),
      .lcd_rs    (lcd_rs),
      .lcd_en    (lcd_en),
      .done_c    (xfer_done_c)
   );

endmodule

// File: tb/tb_lcd1602_ctrl.sv
// Directed testbench for lcd1602_ctrl with shortened timing.
module tb_lcd1602_ctrl;

   localparam int S_CYC   = 2;
   localparam int E_CYC   = 3;
   localparam int H_CYC   = 2;
   localparam int CMD_CYC = 20;
   localparam int CLR_CYC = 60;
   localparam int PWR_CYC = 50;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic       req_rs = 1'b0;
   logic [7:0] req_data = 8'h00;
   logic       init_done;
   logic [7:0] lcd_dat;
   logic       lcd_rs;
   logic       lcd_rw;
   logic       lcd_en;

   int n_err = 0;
   int n_checks = 0;

   lcd1602_ctrl #(
      .SETUP_CYC    (S_CYC),
      .EN_HI_CYC    (E_CYC),
      .HOLD_CYC     (H_CYC),
      .CMD_WAIT_CYC (CMD_CYC),
      .CLR_WAIT_CYC (CLR_CYC),
      .PWR_WAIT_CYC (PWR_CYC)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_rs    (req_rs),
      .req_data  (req_data),
      .init_done (init_done),
      .lcd_dat   (lcd_dat),
      .lcd_rs    (lcd_rs),
      .lcd_rw    (lcd_rw),
      .lcd_en    (lcd_en)
   );

   always #5 clk = ~clk;

   // Free-running cycle number.
   int cyc = 0;
   always @(posedge clk) cyc++;

   // Pulse monitor: records byte, rs, width and stability of every en pulse.
   logic [7:0] p_dat [0:63];
   logic       p_rs  [0:63];
   int         p_w   [0:63];
   bit         p_st  [0:63];
   int         p_fall[0:63];
   int         n_pulse = 0;
   bit         en_prev = 1'b0;
   logic [7:0] m_dat;
   logic       m_rs;
   int         m_w = 0;
   bit         m_st = 1'b0;
   int         hold_left = 0;
   int         h_idx = 0;

   always @(negedge clk) begin
      if (lcd_en && !en_prev) begin
         m_dat = lcd_dat; m_rs = lcd_rs; m_w = 1; m_st = 1'b1;
      end else if (lcd_en) begin
         m_w++;
         if (lcd_dat !== m_dat || lcd_rs !== m_rs) m_st = 1'b0;
      end else if (en_prev) begin
         if (lcd_dat !== m_dat || lcd_rs !== m_rs) m_st = 1'b0;
         if (n_pulse < 64) begin
            p_dat[n_pulse] = m_dat; p_rs[n_pulse] = m_rs; p_w[n_pulse] = m_w;
            p_st[n_pulse] = m_st; p_fall[n_pulse] = cyc;
            h_idx = n_pulse;
         end
         n_pulse++;
         hold_left = H_CYC - 1;
      end else if (hold_left > 0) begin
         if (lcd_dat !== m_dat || lcd_rs !== m_rs) p_st[h_idx] = 1'b0;
         hold_left--;
      end
      en_prev = lcd_en;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ready();
      int g = 0;
      while (!req_ready && g < 5000) begin @(posedge clk); #1; g++; end
      check("wait_ready", 32'(req_ready), 32'd1);
   endtask

   // Wait for init_done; flags any req_ready seen beforehand.
   task automatic wait_init(output bit early_rdy);
      int g = 0;
      early_rdy = 1'b0;
      while (!init_done && g < 5000) begin
         if (req_ready) early_rdy = 1'b1;
         @(posedge clk); #1; g++;
      end
      check("init_done_timeout", 32'(init_done), 32'd1);
   endtask

   // One write; returns accept-to-ready spacing and SETUP-cycle pin values.
   task automatic send_one(input logic rs_v, input logic [7:0] d, output int spacing,
                           output logic [7:0] s_dat, output logic s_rs, output logic s_rdy);
      int n;
      wait_ready();
      req_valid = 1'b1; req_rs = rs_v; req_data = d;
      @(posedge clk); #1;
      req_valid = 1'b0; req_data = 8'hFF; req_rs = ~rs_v;
      s_dat = lcd_dat; s_rs = lcd_rs; s_rdy = req_ready;
      n = 1;
      while (!req_ready && n < 1000) begin @(posedge clk); #1; n++; end
      spacing = n;
   endtask

   logic [7:0] tx [0:31];
   int         acc_cyc [0:31];

   // Holds req_valid high and advances the byte after each accept.
   task automatic send_stream(input int n);
      int k = 0;
      int g = 0;
      bit acc;
      req_valid = 1'b1; req_rs = 1'b1; req_data = tx[0];
      while (k < n && g < 5000) begin
         acc = req_ready && req_valid;
         @(posedge clk); #1; g++;
         if (acc) begin
            acc_cyc[k] = cyc - 1;
            k++;
            if (k < n) req_data = tx[k];
         end
      end
      req_valid = 1'b0;
      check("stream_accepts", 32'(k), 32'(n));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      bit         early;
      int         base;
      int         sp;
      int         g;
      int         n_c0;
      logic [7:0] sd;
      logic       sr;
      logic       srdy;
      logic [7:0] exp_init [0:3];
      exp_init[0] = 8'h38; exp_init[1] = 8'h0C; exp_init[2] = 8'h06; exp_init[3] = 8'h01;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_dat", 32'(lcd_dat), 32'h00);
      check("rst_rs", 32'(lcd_rs), 32'd0);
      check("rst_rw", 32'(lcd_rw), 32'd0);
      check("rst_en", 32'(lcd_en), 32'd0);
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_init_done", 32'(init_done), 32'd0);
      rst = 1'b0;

      // Init sequence
      base = n_pulse;
      wait_init(early);
      check("init_no_early_ready", 32'(early), 32'd0);
      check("init_pulse_count", 32'(n_pulse - base), 32'd4);
      for (int i = 0; i < 4; i++) begin
         check("init_cmd", 32'(p_dat[base + i]), 32'(exp_init[i]));
         check("init_rs", 32'(p_rs[base + i]), 32'd0);
      end
      check("init_done_delay", 32'(cyc - p_fall[base + 3]), 32'(H_CYC + CLR_CYC));
      check("ready_after_init", 32'(req_ready), 32'd1);

      // Single character 'H'
      base = n_pulse;
      send_one(1'b1, 8'h48, sp, sd, sr, srdy);
      check("h_setup_dat", 32'(sd), 32'h48);
      check("h_setup_rs", 32'(sr), 32'd1);
      check("h_ready_low", 32'(srdy), 32'd0);
      check("h_spacing", 32'(sp), 32'(1 + S_CYC + E_CYC + H_CYC + CMD_CYC));
      check("h_pulses", 32'(n_pulse - base), 32'd1);
      check("h_dat", 32'(p_dat[base]), 32'h48);
      check("h_rs", 32'(p_rs[base]), 32'd1);
      check("h_width", 32'(p_w[base]), 32'(E_CYC));
      check("h_stable", 32'(p_st[base]), 32'd1);
      check("rw_zero", 32'(lcd_rw), 32'd0);

      // Three bytes back-to-back with valid held
      tx[0] = 8'h31; tx[1] = 8'h32; tx[2] = 8'h33;
      base = n_pulse;
      send_stream(3);
      check("b2b_gap0", 32'(acc_cyc[1] - acc_cyc[0]), 32'd28);
      check("b2b_gap1", 32'(acc_cyc[2] - acc_cyc[1]), 32'd28);
      wait_ready();
      check("b2b_pulses", 32'(n_pulse - base), 32'd3);
      for (int i = 0; i < 3; i++) begin
         check("b2b_dat", 32'(p_dat[base + i]), 32'(tx[i]));
         check("b2b_rs", 32'(p_rs[base + i]), 32'd1);
      end

      // Clear command uses the long wait
      base = n_pulse;
      send_one(1'b0, 8'h01, sp, sd, sr, srdy);
      check("clr_spacing", 32'(sp), 32'(1 + S_CYC + E_CYC + H_CYC + CLR_CYC));
      check("clr_dat", 32'(p_dat[base]), 32'h01);
      check("clr_rs", 32'(p_rs[base]), 32'd0);

      // 17 characters: line wrap behaviour
      for (int i = 0; i < 17; i++) tx[i] = 8'(8'h41 + i);
      base = n_pulse;
      send_stream(17);
      wait_ready();
`ifdef LCD1602_LINE_WRAP_EN
      check("wrap_pulses", 32'(n_pulse - base), 32'd18);
      check("wrap_addr_dat", 32'(p_dat[base + 16]), 32'hC0);
      check("wrap_addr_rs", 32'(p_rs[base + 16]), 32'd0);
      check("wrap_ch17_dat", 32'(p_dat[base + 17]), 32'h51);
      check("wrap_ch17_rs", 32'(p_rs[base + 17]), 32'd1);
`else
      check("nowrap_pulses", 32'(n_pulse - base), 32'd17);
      check("nowrap_ch17_dat", 32'(p_dat[base + 16]), 32'h51);
      check("nowrap_ch17_rs", 32'(p_rs[base + 16]), 32'd1);
      n_c0 = 0;
      for (int i = 0; i < 17; i++) if (p_dat[base + i] == 8'hC0) n_c0++;
      check("nowrap_no_c0", 32'(n_c0), 32'd0);
`endif
      check("wrap_ch16_dat", 32'(p_dat[base + 15]), 32'h50);

      // Reset during EN_HI, with a request left pending
      wait_ready();
      req_valid = 1'b1; req_rs = 1'b1; req_data = 8'h5A;
      g = 0;
      while (!lcd_en && g < 200) begin @(posedge clk); #1; g++; end
      check("en_seen", 32'(lcd_en), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      check("abort_en", 32'(lcd_en), 32'd0);
      check("abort_ready", 32'(req_ready), 32'd0);
      check("abort_init_done", 32'(init_done), 32'd0);
      check("abort_dat", 32'(lcd_dat), 32'h00);
      @(posedge clk); #1;
      rst = 1'b0;
      base = n_pulse;
      wait_init(early);
      check("reinit_no_early_ready", 32'(early), 32'd0);
      check("reinit_pulse_count", 32'(n_pulse - base), 32'd4);
      for (int i = 0; i < 4; i++) begin
         check("reinit_cmd", 32'(p_dat[base + i]), 32'(exp_init[i]));
      end
      g = 0;
      while (n_pulse < base + 5 && g < 200) begin @(posedge clk); #1; g++; end
      req_valid = 1'b0;
      check("pending_issued", 32'(n_pulse - base), 32'd5);
      check("pending_dat", 32'(p_dat[base + 4]), 32'h5A);
      check("pending_rs", 32'(p_rs[base + 4]), 32'd1);
      wait_ready();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
